// File: rtl/shift_mul_unit.sv
// Iterative MUL/SLL/SRL/SRA execute unit, one step per clock.
// Optional build macro: MUL_EARLY_TERM_EN (MUL stops once the multiplier is exhausted).
module shift_mul_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] val;
  logic             sign;
  logic [CNT_W-1:0] cnt;

  logic [CNT_W-1:0] amt_raw;
  logic [CNT_W-1:0] amt_sat;
  logic [CNT_W-1:0] n_mul;
  logic [CNT_W-1:0] n_start;
  logic [WIDTH-1:0] zero_res;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] val_nx;
  logic [WIDTH-1:0] step_res;

  function automatic logic [CNT_W-1:0] msb_plus1(
    input logic [WIDTH-1:0] v
  );
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) n = CNT_W'(i + 1);
    return n;
  endfunction

  assign amt_raw = CNT_W'(DATA2[3:0]);
  assign amt_sat = (amt_raw > W_CNT) ? W_CNT : amt_raw;

`ifdef MUL_EARLY_TERM_EN
  assign n_mul = msb_plus1(DATA2);
`else
  assign n_mul = W_CNT;
`endif

  assign n_start  = (OP == OP_MUL) ? n_mul : amt_sat;
  // Only zero-step cases: MUL by 0 (early term) or shift by 0.
  assign zero_res = (OP == OP_MUL) ? '0 : DATA1;

  assign acc_nx = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    val_nx = val;
    unique case (op_q)
      OP_SLL:  val_nx = {val[WIDTH-2:0], 1'b0};
      OP_SRL:  val_nx = {1'b0, val[WIDTH-1:1]};
      OP_SRA:  val_nx = {sign, val[WIDTH-1:1]};
      default: val_nx = val;
    endcase
  end

  assign step_res = (op_q == OP_MUL) ? acc_nx : val_nx;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      op_q   <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      val    <= '0;
      sign   <= 1'b0;
      cnt    <= '0;
      RESULT <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            op_q   <= OP;
            acc    <= '0;
            mcand  <= DATA1;
            mplier <= DATA2;
            val    <= DATA1;
            sign   <= DATA1[WIDTH-1];
            cnt    <= n_start;
            if (n_start == '0) begin
              state  <= S_DONE;
              RESULT <= zero_res;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          val    <= val_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= S_DONE;
            RESULT <= step_res;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY = (state == S_RUN);
  assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_shift_mul_unit.sv
// Bench for shift_mul_unit: directed cases plus random ops
// against an arithmetic reference model.
module tb_shift_mul_unit;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [1:0] OP;
  logic [7:0] DATA1;
  logic [7:0] DATA2;
  logic [7:0] RESULT;
  logic       BUSY;
  logic       DONE;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_res;

  shift_mul_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .OP    (OP),
    .DATA1 (DATA1),
    .DATA2 (DATA2),
    .RESULT(RESULT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_n(input logic [1:0] op,
                               input logic [7:0] b);
    int n;
    n = 0;
    if (op == 2'b00) begin
      n = 8;
`ifdef MUL_EARLY_TERM_EN
      n = 0;
      for (int i = 0; i < 8; i++)
        if (b[i]) n = i + 1;
`endif
    end else begin
      n = int'(b[3:0]);
      if (n > 8) n = 8;
    end
    return n;
  endfunction

  function automatic logic [7:0] ref_res(input logic [1:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
    int amt;
    logic [15:0] p;
    logic signed [7:0] s;
    amt = int'(b[3:0]);
    if (amt > 8) amt = 8;
    p = 16'(a) * 16'(b);
    s = a;
    case (op)
      2'b00:   return p[7:0];
      2'b01:   return (amt >= 8) ? 8'h00 : 8'(a << amt);
      2'b10:   return (amt >= 8) ? 8'h00 : 8'(a >> amt);
      default: return (amt >= 8) ? {8{a[7]}} : 8'(s >>> amt);
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input bit noise);
    int n;
    int busy;
    int cyc;
    logic [7:0] exp;
    n = ref_n(op, b);
    exp = ref_res(op, a, b);
    @(negedge CLK);
    START = 1'b1;
    OP = op;
    DATA1 = a;
    DATA2 = b;
    @(negedge CLK);
    START = 1'b0;
    if (noise) begin
      DATA1 = 8'($urandom);
      DATA2 = 8'($urandom);
      OP = 2'($urandom);
    end
    busy = 0;
    cyc = 0;
    while (!DONE && cyc < 40) begin
      if (BUSY) busy++;
      check("held_in_run", RESULT, last_res);
      if (noise) START = 1'($urandom_range(0, 1));
      @(negedge CLK);
      cyc++;
    end
    check("done_seen", DONE, 1);
    check("busy_cycles", busy, n);
    check("result", RESULT, exp);
    check("busy_in_done", BUSY, 0);
    last_res = exp;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("done_single", DONE, 0);
    check("idle_busy", BUSY, 0);
    check("result_hold", RESULT, exp);
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b1;
    OP = 2'b00;
    DATA1 = 8'h00;
    DATA2 = 8'h00;
    repeat (2) @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_result", RESULT, 0);
    RESET = 1'b0;
    START = 1'b0;
    last_res = 8'h00;
    @(negedge CLK);
    check("post_rst_idle", BUSY, 0);

    run_op(2'b00, 8'h07, 8'h06, 1'b0);
    run_op(2'b00, 8'h10, 8'h20, 1'b0);
    run_op(2'b00, 8'hFF, 8'hFF, 1'b0);
    run_op(2'b00, 8'h03, 8'h00, 1'b0);
    run_op(2'b11, 8'h80, 8'h03, 1'b0);
    run_op(2'b10, 8'h80, 8'h03, 1'b0);
    run_op(2'b01, 8'h81, 8'h01, 1'b0);
    run_op(2'b01, 8'h5A, 8'h00, 1'b0);
    run_op(2'b10, 8'hFF, 8'h0C, 1'b0);
    run_op(2'b11, 8'h80, 8'h0F, 1'b0);
    run_op(2'b00, 8'h07, 8'h06, 1'b1);

    @(negedge CLK);
    START = 1'b1;
    OP = 2'b00;
    DATA1 = 8'h07;
    DATA2 = 8'hFF;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_result", RESULT, 0);
    RESET = 1'b0;
    last_res = 8'h00;
    @(negedge CLK);
    check("abort_no_done", DONE, 0);
    check("abort_idle", BUSY, 0);
    run_op(2'b00, 8'h03, 8'h05, 1'b0);

    for (int k = 0; k < 40; k++)
      run_op(2'($urandom), 8'($urandom), 8'($urandom), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
